// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit: single-outstanding imem read, redirect flush, 2-entry decode buffer
module instr_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_en,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_DROP     = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] buf_pc_q   [2];
    logic [31:0] buf_pc_d   [2];
    logic [31:0] buf_data_q [2];
    logic [31:0] buf_data_d [2];

    logic issue;
    logic push;
    logic pop;

    assign issue = (state_q == S_IDLE) && !redirect && (count_q < 2'd2);
    assign push  = (state_q == S_WAIT_ACK) && imem_ack && !redirect;
    assign pop   = (count_q != 2'd0) && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (redirect) begin
                    state_d = imem_ack ? S_IDLE : S_DROP;
                end else if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Redirect outranks the ack-driven increment; reset silences both so the PC's own reset wins.
    always_comb begin
        imem_req = 1'b0;
        pc_en    = 1'b0;
        pc_next  = 32'd0;
        if (!rst) begin
            imem_req = (state_q == S_WAIT_ACK) || (state_q == S_DROP);
            if (redirect) begin
                pc_en   = 1'b1;
                pc_next = redirect_pc;
            end else if (push) begin
                pc_en   = 1'b1;
                pc_next = imem_addr_q + 32'd4;
            end
        end
    end

    always_comb begin
        imem_addr_d = imem_addr_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_pc_d    = buf_pc_q;
        buf_data_d  = buf_data_q;

        if (issue) begin
            imem_addr_d = pc_in;
        end

        if (push) begin
            buf_pc_d[wr_ptr_q]   = imem_addr_q;
            buf_data_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d             = ~wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end

        // Flush: everything buffered belongs to the abandoned path.
        if (redirect) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_addr_q <= 32'd0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            buf_pc_q    <= '{default: 32'd0};
            buf_data_q  <= '{default: 32'd0};
        end else begin
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_pc_q    <= buf_pc_d;
            buf_data_q  <= buf_data_d;
        end
    end

    always_comb begin
        imem_addr   = 32'd0;
        instr_valid = 1'b0;
        instr_data  = 32'd0;
        instr_pc    = 32'd0;
        if (!rst) begin
            imem_addr   = imem_addr_q;
            instr_valid = (count_q != 2'd0);
            instr_data  = buf_data_q[rd_ptr_q];
            instr_pc    = buf_pc_q[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with PC register and memory models
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_in;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic        pc_set = 1'b1;
    logic [31:0] pc_set_val = 32'd0;
    logic [31:0] pc_reg = 32'd0;

    logic        mem_manual = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    logic        auto_ack = 1'b0;
    logic [31:0] auto_rdata = 32'd0;
    int          mem_lat = 0;
    int          mem_limit = 0;
    int          acks_given = 0;
    int          wait_cnt = 0;

    always #10 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_en       (pc_en),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    assign pc_in      = pc_reg;
    assign imem_ack   = mem_manual ? man_ack : auto_ack;
    assign imem_rdata = mem_manual ? man_rdata : auto_rdata;

    always @(posedge clk) begin
        if (pc_set) pc_reg <= pc_set_val;
        else if (pc_en) pc_reg <= pc_next;
    end

    always begin
        @(negedge clk);
        #1;
        if (!mem_manual && imem_req && (acks_given < mem_limit)) begin
            if (wait_cnt >= mem_lat) begin
                auto_ack   = 1'b1;
                auto_rdata = mem_word(imem_addr);
                wait_cnt   = 0;
                acks_given = acks_given + 1;
            end else begin
                auto_ack = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            auto_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic sb_sample();
        exp_t e;
        #1;
        if (instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got pc=%h data=%h required none", instr_pc, instr_data);
            end else begin
                e = exp_q.pop_front();
                if (instr_pc !== e.pc || instr_data !== e.data) begin
                    errors++;
                    $display("FAIL sb_entry got pc=%h data=%h required pc=%h data=%h",
                             instr_pc, instr_data, e.pc, e.data);
                end
            end
        end
    endtask

    task automatic tick();
        sb_sample();
        @(negedge clk);
        #2;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain got %0d left required 0", name, exp_q.size());
        end
    endtask

    task automatic do_reset(input logic [31:0] pc);
        rst         = 1'b1;
        pc_set      = 1'b1;
        pc_set_val  = pc;
        redirect    = 1'b0;
        man_ack     = 1'b0;
        mem_manual  = 1'b0;
        instr_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
    endtask

    task automatic release_rst();
        rst    = 1'b0;
        pc_set = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset(32'h0000_1000);
        redirect    = 1'b1;
        redirect_pc = 32'h1234_5678;
        #1;
        checks += 6;
        if (pc_en !== 1'b0)       begin errors++; $display("FAIL rst_pc_en got %b required 0", pc_en); end
        if (pc_next !== 32'd0)    begin errors++; $display("FAIL rst_pc_next got %h required 0", pc_next); end
        if (imem_req !== 1'b0)    begin errors++; $display("FAIL rst_req got %b required 0", imem_req); end
        if (imem_addr !== 32'd0)  begin errors++; $display("FAIL rst_addr got %h required 0", imem_addr); end
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b required 0", instr_valid); end
        if (instr_pc !== 32'd0 || instr_data !== 32'd0) begin
            errors++; $display("FAIL rst_instr got pc=%h data=%h required 0", instr_pc, instr_data);
        end
        redirect = 1'b0;
    endtask

    task automatic test_first_fetch();
        do_reset(32'h0100_0000);
        instr_ready = 1'b1;
        mem_lat     = 0;
        mem_limit   = acks_given + 4;
        for (int i = 0; i < 4; i++) push_exp(32'h0100_0000 + 32'(4 * i));
        release_rst();
        #1;
        checks += 3;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0100_0000) begin
            errors++; $display("FAIL first_req got req=%b addr=%h required 1 01000000", imem_req, imem_addr);
        end
        if (pc_en !== 1'b1)              begin errors++; $display("FAIL first_pc_en got %b required 1", pc_en); end
        if (pc_next !== 32'h0100_0004)   begin errors++; $display("FAIL first_pc_next got %h required 01000004", pc_next); end
        tick();
        checks += 2;
        if (instr_valid !== 1'b1)        begin errors++; $display("FAIL first_valid got %b required 1", instr_valid); end
        if (instr_pc !== 32'h0100_0000)  begin errors++; $display("FAIL first_instr_pc got %h required 01000000", instr_pc); end
        if (imem_req !== 1'b0) begin
            checks++; errors++; $display("FAIL first_idle_req got %b required 0", imem_req);
        end
        wait_drain("first_fetch", 40);
    endtask

    task automatic test_backpressure();
        logic [31:0] held_data;
        do_reset(32'h0040_0000);
        mem_lat   = 0;
        mem_limit = acks_given + 3;
        for (int i = 0; i < 3; i++) push_exp(32'h0040_0000 + 32'(4 * i));
        release_rst();
        for (int i = 0; i < 6; i++) tick();
        checks += 2;
        if (instr_valid !== 1'b1)       begin errors++; $display("FAIL bp_valid got %b required 1", instr_valid); end
        if (instr_pc !== 32'h0040_0000) begin errors++; $display("FAIL bp_head_pc got %h required 00400000", instr_pc); end
        held_data = instr_data;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 2;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_no_third_req got %b required 0", imem_req); end
            if (instr_data !== held_data || instr_pc !== 32'h0040_0000) begin
                errors++; $display("FAIL bp_stable got pc=%h data=%h required pc=00400000 data=%h",
                                   instr_pc, instr_data, held_data);
            end
        end
        instr_ready = 1'b1;
        wait_drain("backpressure", 40);
    endtask

    task automatic test_redirect_wait();
        do_reset(32'h0100_0000);
        mem_manual  = 1'b1;
        instr_ready = 1'b1;
        release_rst();
        redirect    = 1'b1;
        redirect_pc = 32'h0100_0100;
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 32'h0100_0100) begin
            errors++; $display("FAIL rw_redirect got en=%b next=%h required 1 01000100", pc_en, pc_next);
        end
        tick();
        redirect = 1'b0;
        #1;
        checks += 2;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL rw_drop_req got %b required 1", imem_req); end
        if (pc_en !== 1'b0 || pc_next !== 32'd0) begin
            errors++; $display("FAIL rw_drop_quiet got en=%b next=%h required 0 0", pc_en, pc_next);
        end
        tick();
        tick();
        man_ack   = 1'b1;
        man_rdata = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (pc_en !== 1'b0) begin errors++; $display("FAIL rw_late_ack_pc_en got %b required 0", pc_en); end
        tick();
        man_ack = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL rw_discard got req=%b valid=%b required 0 0", imem_req, instr_valid);
        end
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0100_0100) begin
            errors++; $display("FAIL rw_new_addr got req=%b addr=%h required 1 01000100", imem_req, imem_addr);
        end
        push_exp(32'h0100_0100);
        man_ack   = 1'b1;
        man_rdata = mem_word(32'h0100_0100);
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 32'h0100_0104) begin
            errors++; $display("FAIL rw_next_ack got en=%b next=%h required 1 01000104", pc_en, pc_next);
        end
        tick();
        man_ack = 1'b0;
        wait_drain("redirect_wait", 10);
    endtask

    task automatic test_redirect_ack();
        do_reset(32'h0020_0000);
        mem_manual = 1'b1;
        release_rst();
        man_ack   = 1'b1;
        man_rdata = mem_word(32'h0020_0000);
        tick();
        man_ack = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL ra_prefill got %b required 1", instr_valid); end
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0200_0000;
        man_ack     = 1'b1;
        man_rdata   = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 32'h0200_0000) begin
            errors++; $display("FAIL ra_pc got en=%b next=%h required 1 02000000", pc_en, pc_next);
        end
        tick();
        redirect = 1'b0;
        man_ack  = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++; $display("FAIL ra_flushed got valid=%b req=%b required 0 0", instr_valid, imem_req);
        end
        instr_ready = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_wrap();
        do_reset(32'hFFFF_FFFC);
        instr_ready = 1'b1;
        mem_lat     = 0;
        mem_limit   = acks_given + 1;
        push_exp(32'hFFFF_FFFC);
        release_rst();
        #1;
        checks++;
        if (pc_en !== 1'b1 || pc_next !== 32'h0000_0000) begin
            errors++; $display("FAIL wrap got en=%b next=%h required 1 00000000", pc_en, pc_next);
        end
        wait_drain("wrap", 10);
    endtask

    task automatic test_latency_unaligned();
        do_reset(32'h0000_1003);
        mem_lat   = 2;
        mem_limit = acks_given + 3;
        for (int i = 0; i < 3; i++) push_exp(32'h0000_1003 + 32'(4 * i));
        release_rst();
        checks++;
        if (imem_addr !== 32'h0000_1003) begin
            errors++; $display("FAIL lat_addr_bits got %h required 00001003", imem_addr);
        end
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            instr_ready = 1'($urandom_range(0, 1));
            tick();
        end
        instr_ready = 1'b1;
        wait_drain("latency", 10);
    endtask

    task automatic test_reset_mid();
        do_reset(32'h0030_0000);
        mem_manual = 1'b1;
        release_rst();
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL rm_pre_req got %b required 1", imem_req); end
        rst         = 1'b1;
        pc_set      = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hDEAD_0000;
        #1;
        checks++;
        if (pc_en !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'd0) begin
            errors++; $display("FAIL rm_in_rst got en=%b req=%b addr=%h required 0 0 0", pc_en, imem_req, imem_addr);
        end
        tick();
        rst       = 1'b0;
        pc_set    = 1'b0;
        redirect  = 1'b0;
        man_ack   = 1'b1;
        man_rdata = 32'hCAFE_F00D;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_en !== 1'b0) begin
            errors++; $display("FAIL rm_late_ack got req=%b en=%b required 0 0", imem_req, pc_en);
        end
        tick();
        man_ack = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 32'h0030_0000) begin
            errors++; $display("FAIL rm_after got valid=%b addr=%h required 0 00300000", instr_valid, imem_addr);
        end
    endtask

    initial begin
        @(negedge clk);
        #2;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_latency_unaligned();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
